// File: rtl/spi1_controller.sv
// SPI1 bus initiator: turns a valid/ready byte stream into mode-0 SPI frames
// (CS low, SCK idle low, MSB first), captures the target's serial data and
// waits at byte boundaries while the target raises its stall line.
module spi1_controller #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SCK_DIV    = 4,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_last_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  spi_cs_no,
  output logic                  spi_sck_o,
  output logic                  spi_sd_o,
  input  logic                  spi_sd_i,
  input  logic                  spi_stall_i
);

  localparam int unsigned PHASES  = 2 * DATA_WIDTH;
  localparam int unsigned PH_W    = $clog2(PHASES);
  localparam int unsigned MAX_SD  = (SCK_DIV > CS_SETUP) ? SCK_DIV : CS_SETUP;
  localparam int unsigned CNT_MAX = (MAX_SD > CS_HOLD) ? MAX_SD : CS_HOLD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STALL,
    S_SHIFT,
    S_NEXT,
    S_HOLD
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [PH_W-1:0]       phase;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  last_q;
  logic                  stall_meta;
  logic                  stall_sync;
  logic                  accept_c;

  // Byte handshake; ready is registered and depends on state only.
  assign accept_c = tx_valid_i && tx_ready_o;

  // Two-flop synchroniser for the asynchronous target stall line.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stall_meta <= 1'b0;
      stall_sync <= 1'b0;
    end else begin
      stall_meta <= spi_stall_i;
      stall_sync <= stall_meta;
    end
  end

  // Frame sequencer with registered SPI and stream outputs.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= S_IDLE;
      cnt        <= '0;
      phase      <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      last_q     <= 1'b0;
      tx_ready_o <= 1'b1;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      spi_cs_no  <= 1'b1;
      spi_sck_o  <= 1'b0;
      spi_sd_o   <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            tx_sr      <= tx_data_i;
            last_q     <= tx_last_i;
            spi_sd_o   <= tx_data_i[DATA_WIDTH-1];
            spi_cs_no  <= 1'b0;
            tx_ready_o <= 1'b0;
            busy_o     <= 1'b1;
            cnt        <= '0;
            // The STALL cycle itself provides the final cycle of CS setup.
            state      <= (CS_SETUP > 1) ? S_SETUP : S_STALL;
          end
        end

        S_SETUP: begin
          if (cnt == CNT_W'(CS_SETUP - 2)) begin
            cnt   <= '0;
            state <= S_STALL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STALL: begin
          if (!stall_sync) begin
            spi_sck_o <= 1'b1;
            cnt       <= '0;
            phase     <= '0;
            state     <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (cnt == CNT_W'(SCK_DIV - 1)) begin
            cnt <= '0;
            if (!phase[0]) begin
              // End of high phase: capture target bit, then drop SCK and present next bit.
              rx_sr     <= {rx_sr[DATA_WIDTH-2:0], spi_sd_i};
              tx_sr     <= tx_sr << 1;
              spi_sd_o  <= tx_sr[DATA_WIDTH-2];
              spi_sck_o <= 1'b0;
              phase     <= phase + 1'b1;
            end else if (phase == PH_W'(PHASES - 1)) begin
              rx_data_o  <= rx_sr;
              rx_valid_o <= 1'b1;
              if (last_q) begin
                state <= S_HOLD;
              end else begin
                tx_ready_o <= 1'b1;
                state      <= S_NEXT;
              end
            end else begin
              spi_sck_o <= 1'b1;
              phase     <= phase + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_NEXT: begin
          if (accept_c) begin
            tx_sr      <= tx_data_i;
            last_q     <= tx_last_i;
            spi_sd_o   <= tx_data_i[DATA_WIDTH-1];
            tx_ready_o <= 1'b0;
            state      <= S_STALL;
          end
        end

        S_HOLD: begin
          if (cnt == CNT_W'(CS_HOLD - 1)) begin
            cnt        <= '0;
            spi_cs_no  <= 1'b1;
            tx_ready_o <= 1'b1;
            busy_o     <= 1'b0;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi1_controller.sv
// Bench for spi1_controller: a cycle-level SPI target model records MOSI bytes,
// supplies MISO bytes, and the stimulus compares against expected frame contents.
module tb_spi1_controller;

  localparam int unsigned DW       = 8;
  localparam int unsigned SCK_DIV  = 4;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int unsigned BYTE_CYC = 2 * SCK_DIV * DW;

  logic          clock_i = 1'b0;
  logic          reset_ni;
  logic [DW-1:0] tx_data_i;
  logic          tx_last_i;
  logic          tx_valid_i;
  logic          tx_ready_o;
  logic [DW-1:0] rx_data_o;
  logic          rx_valid_o;
  logic          busy_o;
  logic          spi_cs_no;
  logic          spi_sck_o;
  logic          spi_sd_o;
  logic          spi_sd_i;
  logic          spi_stall_i;

  logic          loopback;
  logic [7:0]    miso_cur = 8'h00;
  logic [2:0]    miso_idx = 3'd7;

  int n_checks = 0;
  int n_fail   = 0;

  // Target-side monitor state
  int cyc = 0, rises = 0, cs_falls = 0, cs_rises = 0;
  int last_cs_low = 0, cs_low_run = 0, sd_viol = 0, rxv_viol = 0;
  int acc_cnt = 0, rx_cnt = 0, ready_rise_cs_low = 0, last_rise_cyc = 0;
  int mosi_bits = 0;
  logic [7:0] mosi_sr = 8'h00;
  logic [7:0] mosi_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] miso_q[$];
  logic prev_sck = 1'b0, prev_cs = 1'b1, prev_sd = 1'b0, prev_rxv = 1'b0, prev_ready = 1'b1;

  logic [7:0] fr_tx[3];
  logic [7:0] fr_rx[3];

  always #5 clock_i = ~clock_i;

  assign spi_sd_i = loopback ? spi_sd_o : miso_cur[miso_idx];

  spi1_controller #(
    .DATA_WIDTH(DW),
    .SCK_DIV   (SCK_DIV),
    .CS_SETUP  (CS_SETUP),
    .CS_HOLD   (CS_HOLD)
  ) dut (
    .clock_i    (clock_i),
    .reset_ni   (reset_ni),
    .tx_data_i  (tx_data_i),
    .tx_last_i  (tx_last_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .busy_o     (busy_o),
    .spi_cs_no  (spi_cs_no),
    .spi_sck_o  (spi_sck_o),
    .spi_sd_o   (spi_sd_o),
    .spi_sd_i   (spi_sd_i),
    .spi_stall_i(spi_stall_i)
  );

  // Mode-0 target model and bus observer, sampled mid-cycle.
  always @(negedge clock_i) begin
    cyc++;
    if (!spi_cs_no) cs_low_run++;
    if (!spi_cs_no && prev_cs) begin
      cs_falls++;
      mosi_bits = 0;
      miso_cur  = (miso_q.size() != 0) ? miso_q.pop_front() : 8'h00;
      miso_idx  = 3'd7;
    end
    if (spi_cs_no && !prev_cs) begin
      cs_rises++;
      last_cs_low = cs_low_run;
      cs_low_run  = 0;
    end
    if (spi_sck_o && !prev_sck) begin
      rises++;
      last_rise_cyc = cyc;
      mosi_sr = {mosi_sr[6:0], spi_sd_o};
      mosi_bits++;
      if (mosi_bits == 8) begin
        mosi_q.push_back(mosi_sr);
        mosi_bits = 0;
      end
    end
    if (!spi_sck_o && prev_sck) begin
      if (miso_idx == 3'd0) begin
        miso_cur = (miso_q.size() != 0) ? miso_q.pop_front() : 8'h00;
        miso_idx = 3'd7;
      end else begin
        miso_idx = miso_idx - 3'd1;
      end
    end
    if (spi_sck_o && prev_sck && (spi_sd_o !== prev_sd)) sd_viol++;
    if (rx_valid_o) begin
      rx_q.push_back(rx_data_o);
      rx_cnt++;
      if (prev_rxv) rxv_viol++;
    end
    if (tx_valid_i && tx_ready_o) acc_cnt++;
    if (tx_ready_o && !prev_ready && !spi_cs_no) ready_rise_cs_low++;
    prev_sck   = spi_sck_o;
    prev_cs    = spi_cs_no;
    prev_sd    = spi_sd_o;
    prev_rxv   = rx_valid_o;
    prev_ready = tx_ready_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pop_mosi();
    if (mosi_q.size() == 0) return 'x;
    return 32'(mosi_q.pop_front());
  endfunction

  function automatic logic [31:0] pop_rx();
    if (rx_q.size() == 0) return 'x;
    return 32'(rx_q.pop_front());
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic l, output logic ok);
    @(posedge clock_i); #1;
    tx_data_i  = d;
    tx_last_i  = l;
    tx_valid_i = 1'b1;
    ok         = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock_i);
      if (tx_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clock_i); #1;
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock_i);
      if (spi_cs_no && !busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clock_i); #1;
  endtask

  // One CS window of n bytes presented back to back; expectations from frame contents.
  task automatic do_frame(input string tag, input int n, input logic lb);
    int r0, f0, a0, q0;
    logic ok;
    r0 = rises; f0 = cs_rises; a0 = acc_cnt; q0 = ready_rise_cs_low;
    loopback = lb;
    if (!lb) for (int i = 0; i < n; i++) miso_q.push_back(fr_rx[i]);
    for (int i = 0; i < n; i++) begin
      send_byte(fr_tx[i], (i == n - 1), ok);
      chk({tag, "_accept"}, 32'(ok), 32'd1);
    end
    wait_idle(ok);
    chk({tag, "_idle"}, 32'(ok), 32'd1);
    chk({tag, "_sck_pulses"}, 32'(rises - r0), 32'(8 * n));
    chk({tag, "_cs_windows"}, 32'(cs_rises - f0), 32'd1);
    chk({tag, "_accepts"}, 32'(acc_cnt - a0), 32'(n));
    chk({tag, "_ready_in_next"}, 32'(ready_rise_cs_low - q0), 32'(n - 1));
    chk({tag, "_cs_low_cycles"}, 32'(last_cs_low),
        32'(CS_SETUP + n * BYTE_CYC + (n - 1) * 2 + CS_HOLD));
    for (int i = 0; i < n; i++) begin
      chk({tag, "_mosi"}, pop_mosi(), 32'(fr_tx[i]));
      chk({tag, "_rx"}, pop_rx(), 32'(lb ? fr_tx[i] : fr_rx[i]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ok;
    logic [7:0] b1, b2;
    int r0, rx0, a0, drop_cyc;

    reset_ni = 1'b0; tx_valid_i = 1'b0; tx_data_i = '0; tx_last_i = 1'b0;
    spi_stall_i = 1'b0; loopback = 1'b1;
    repeat (3) @(posedge clock_i);
    #1 reset_ni = 1'b1;
    repeat (10) @(posedge clock_i);
    @(negedge clock_i); #1;

    // Idle state after reset
    chk("rst_cs", 32'(spi_cs_no), 32'd1);
    chk("rst_sck", 32'(spi_sck_o), 32'd0);
    chk("rst_sd", 32'(spi_sd_o), 32'd0);
    chk("rst_ready", 32'(tx_ready_o), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    chk("rst_rx_data", 32'(rx_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);

    // Single byte 0xA5 in loopback
    fr_tx[0] = 8'hA5;
    do_frame("a5_loop", 1, 1'b1);

    // Three-byte frame against target data
    fr_tx[0] = 8'h12; fr_tx[1] = 8'h34; fr_tx[2] = 8'h56;
    fr_rx[0] = 8'h00; fr_rx[1] = 8'hFF; fr_rx[2] = 8'h3C;
    do_frame("three_byte", 3, 1'b0);

    // Randomised frames
    for (int k = 0; k < 6; k++) begin
      int n;
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < 3; i++) begin
        fr_tx[i] = 8'($urandom);
        fr_rx[i] = 8'($urandom);
      end
      do_frame("rand", n, 1'($urandom));
    end

    // Stall held between bytes of a two-byte frame
    loopback = 1'b1;
    b1 = 8'($urandom); b2 = 8'($urandom);
    rx0 = rx_cnt;
    send_byte(b1, 1'b0, ok);
    chk("stall_b1_accept", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock_i); #1;
      if (rx_cnt != rx0) begin ok = 1'b1; break; end
    end
    chk("stall_b1_done", 32'(ok), 32'd1);
    spi_stall_i = 1'b1;
    repeat (3) @(posedge clock_i);
    send_byte(b2, 1'b1, ok);
    chk("stall_b2_accept", 32'(ok), 32'd1);
    r0 = rises;
    repeat (50) @(posedge clock_i);
    #1;
    chk("stall_no_sck", 32'(rises - r0), 32'd0);
    chk("stall_cs_held", 32'(spi_cs_no), 32'd0);
    @(posedge clock_i); #1;
    spi_stall_i = 1'b0;
    drop_cyc = cyc;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock_i); #1;
      if (rises != r0) begin ok = 1'b1; break; end
    end
    chk("stall_resume", 32'(ok), 32'd1);
    // two synchroniser flops plus the registered SCK: third clock edge after release
    chk("stall_resume_edges", 32'(last_rise_cyc - drop_cyc - 1), 32'd3);
    wait_idle(ok);
    chk("stall_idle", 32'(ok), 32'd1);
    chk("stall_mosi1", pop_mosi(), 32'(b1));
    chk("stall_mosi2", pop_mosi(), 32'(b2));
    chk("stall_rx1", pop_rx(), 32'(b1));
    chk("stall_rx2", pop_rx(), 32'(b2));

    // Stall raised mid-byte must not pause the byte in progress
    b1 = 8'($urandom);
    r0 = rises;
    send_byte(b1, 1'b1, ok);
    for (int i = 0; i < 500; i++) begin
      @(negedge clock_i); #1;
      if (rises - r0 >= 2) break;
    end
    spi_stall_i = 1'b1;
    wait_idle(ok);
    spi_stall_i = 1'b0;
    chk("midstall_idle", 32'(ok), 32'd1);
    chk("midstall_pulses", 32'(rises - r0), 32'd8);
    chk("midstall_cs_low", 32'(last_cs_low), 32'(CS_SETUP + BYTE_CYC + CS_HOLD));
    chk("midstall_rx", pop_rx(), 32'(b1));
    chk("midstall_mosi", pop_mosi(), 32'(b1));
    repeat (4) @(posedge clock_i);

    // Reset asserted after three SCK pulses
    b1 = 8'($urandom);
    r0 = rises; rx0 = rx_cnt;
    send_byte(b1, 1'b1, ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock_i); #1;
      if (rises - r0 >= 3) begin ok = 1'b1; break; end
    end
    chk("rstmid_reach", 32'(ok), 32'd1);
    reset_ni = 1'b0;
    #1;
    chk("rstmid_cs", 32'(spi_cs_no), 32'd1);
    chk("rstmid_sck", 32'(spi_sck_o), 32'd0);
    chk("rstmid_ready", 32'(tx_ready_o), 32'd1);
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    repeat (5) @(posedge clock_i);
    #1 reset_ni = 1'b1;
    repeat (5) @(posedge clock_i);
    #1;
    chk("rstmid_no_rx", 32'(rx_cnt - rx0), 32'd0);
    fr_tx[0] = 8'($urandom);
    do_frame("after_rst", 1, 1'b1);

    // Valid held high while busy: second byte taken only once, in NEXT
    loopback = 1'b1;
    b1 = 8'($urandom); b2 = 8'($urandom);
    a0 = acc_cnt; rx0 = rx_cnt;
    send_byte(b1, 1'b0, ok);
    chk("hold_b1_accept", 32'(ok), 32'd1);
    tx_data_i = b2; tx_last_i = 1'b1; tx_valid_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock_i);
      if (tx_ready_o) begin ok = 1'b1; break; end
    end
    #1;
    chk("hold_ready_seen", 32'(ok), 32'd1);
    chk("hold_ready_after_rx", 32'(rx_cnt - rx0), 32'd1);
    @(posedge clock_i); #1;
    tx_valid_i = 1'b0;
    wait_idle(ok);
    chk("hold_idle", 32'(ok), 32'd1);
    chk("hold_accepts", 32'(acc_cnt - a0), 32'd2);
    chk("hold_mosi1", pop_mosi(), 32'(b1));
    chk("hold_mosi2", pop_mosi(), 32'(b2));
    chk("hold_rx1", pop_rx(), 32'(b1));
    chk("hold_rx2", pop_rx(), 32'(b2));

    // Whole-run bus rules
    chk("sd_stable_while_sck_high", 32'(sd_viol), 32'd0);
    chk("rx_valid_single_cycle", 32'(rxv_viol), 32'd0);
    chk("rx_queue_drained", 32'(rx_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
